bcd_counter4: RTL and testbench

BCD_COUNTER4 -- requirements
Module: bcd_counter4

---
 rtl/bcd_counter4.sv | 168 ++++++++++++++++
 tb/tb_bcd_counter4.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter4.sv
// Four-digit BCD up/down counter with a programmable tick prescaler.
// The digits advance once per prescaler tick when enabled. Clear and load
// take priority over counting and restart the prescaler. The carry and borrow
// outputs pulse on a wrap past 9999 or 0000. All outputs are registered.
module bcd_counter4 #(
   parameter int TICK_DIV = 50000000
) (
   input  logic        iClk,
   input  logic        iRst_n,
   input  logic        iEn,
   input  logic        iUp,
   input  logic        iClear,
   input  logic        iLoad,
   input  logic [15:0] iLoadData,
   output logic [3:0]  oDigit0,
   output logic [3:0]  oDigit1,
   output logic [3:0]  oDigit2,
   output logic [3:0]  oDigit3,
   output logic        oCarry,
   output logic        oBorrow,
   output logic        oZero
);

   // Wide enough for the largest legal divider (2^26), so the terminal count fits.
   localparam int                 PRESC_W    = 27;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
   localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

   // Stage p0: prescaler state and the tick decoded from it.
   logic [PRESC_W-1:0] prescCount_p0;
   logic               tick_p0;

   // Combinational next-state values for the digit register.
   logic [15:0] digitsNext_p0;
   logic        carryNext_p0;
   logic        borrowNext_p0;
   logic        countEn_p0;

   // Stage p1: registered digits and flags that drive the outputs.
   logic [15:0] digits_p1;

   // Forces one loaded nibble into the legal BCD range. Values above 9 become 0.
   function automatic logic [3:0] sanitizeNibble(input logic [3:0] n);
      return (n > 4'd9) ? 4'd0 : n;
   endfunction

   // Sanitizes all four load nibbles independently.
   function automatic logic [15:0] sanitizeLoad(input logic [15:0] d);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = sanitizeNibble(d[i*4 +: 4]);
      end
      return r;
   endfunction

   // Ripple BCD increment. A digit at 9 (or above) wraps to 0 and passes the
   // carry on. A digit without an incoming carry is held.
   function automatic logic [15:0] bcdInc(input logic [15:0] d);
      logic [15:0] r;
      logic        c;
      r = d;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (d[i*4 +: 4] >= 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = d[i*4 +: 4] + 4'd1;
               c           = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Ripple BCD decrement. A digit at 0 wraps to 9 and borrows from the next
   // digit.
   function automatic logic [15:0] bcdDec(input logic [15:0] d);
      logic [15:0] r;
      logic        b;
      r = d;
      b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (b) begin
            if (d[i*4 +: 4] == 4'd0) begin
               r[i*4 +: 4] = 4'd9;
            end else if (d[i*4 +: 4] > 4'd9) begin
               r[i*4 +: 4] = 4'd8;
               b           = 1'b0;
            end else begin
               r[i*4 +: 4] = d[i*4 +: 4] - 4'd1;
               b           = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // True when every digit is 9, which is the up-count wrap point.
   function automatic logic isAllNine(input logic [15:0] d);
      return d == 16'h9999;
   endfunction

   // True when every digit is 0, which is the down-count wrap point.
   function automatic logic isAllZero(input logic [15:0] d);
      return d == 16'h0000;
   endfunction

   assign tick_p0    = (prescCount_p0 == PRESC_LAST);
   assign countEn_p0 = tick_p0 & iEn & ~iClear & ~iLoad;

   // Free-running prescaler. It keeps running while iEn is low, so the tick
   // phase is preserved across a pause. Clear and load restart it at 0.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         prescCount_p0 <= '0;
      end else if (iClear || iLoad) begin
         prescCount_p0 <= '0;
      end else if (tick_p0) begin
         prescCount_p0 <= '0;
      end else begin
         prescCount_p0 <= prescCount_p0 + PRESC_ONE;
      end
   end

   // Next digit values and wrap flags. Priority is clear, then load, then count.
   always_comb begin
      digitsNext_p0 = digits_p1;
      carryNext_p0  = 1'b0;
      borrowNext_p0 = 1'b0;
      if (iClear) begin
         digitsNext_p0 = '0;
      end else if (iLoad) begin
         digitsNext_p0 = sanitizeLoad(iLoadData);
      end else if (countEn_p0) begin
         if (iUp) begin
            digitsNext_p0 = bcdInc(digits_p1);
            carryNext_p0  = isAllNine(digits_p1);
         end else begin
            digitsNext_p0 = bcdDec(digits_p1);
            borrowNext_p0 = isAllZero(digits_p1);
         end
      end
   end

   // Stage p1: digit register plus the wrap pulses and the zero flag. Every
   // flag is aligned with the digit value it describes.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         digits_p1 <= '0;
         oCarry    <= 1'b0;
         oBorrow   <= 1'b0;
         oZero     <= 1'b1;
      end else begin
         digits_p1 <= digitsNext_p0;
         oCarry    <= carryNext_p0;
         oBorrow   <= borrowNext_p0;
         oZero     <= isAllZero(digitsNext_p0);
      end
   end

   assign oDigit0 = digits_p1[3:0];
   assign oDigit1 = digits_p1[7:4];
   assign oDigit2 = digits_p1[11:8];
   assign oDigit3 = digits_p1[15:12];

endmodule

// File: tb/tb_bcd_counter4.sv
// Testbench for bcd_counter4. It runs two instances, TICK_DIV=4 and TICK_DIV=1,
// against a decimal reference model through an expected-value queue.
module tb_bcd_counter4;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [1:0]  en, up, clr, ld;
   logic [15:0] ldData [2];

   logic [3:0]  aD0, aD1, aD2, aD3, bD0, bD1, bD2, bD3;
   logic        aC, aB, aZ, bC, bB, bZ;
   logic [15:0] obsDig [2];
   logic [1:0]  obsC, obsB, obsZ;

   assign obsDig[0] = {aD3, aD2, aD1, aD0};
   assign obsDig[1] = {bD3, bD2, bD1, bD0};
   assign obsC      = {bC, aC};
   assign obsB      = {bB, aB};
   assign obsZ      = {bZ, aZ};

   bcd_counter4 #(.TICK_DIV(4)) dutA (
      .iClk(clk), .iRst_n(rst_n), .iEn(en[0]), .iUp(up[0]), .iClear(clr[0]),
      .iLoad(ld[0]), .iLoadData(ldData[0]),
      .oDigit0(aD0), .oDigit1(aD1), .oDigit2(aD2), .oDigit3(aD3),
      .oCarry(aC), .oBorrow(aB), .oZero(aZ));

   bcd_counter4 #(.TICK_DIV(1)) dutB (
      .iClk(clk), .iRst_n(rst_n), .iEn(en[1]), .iUp(up[1]), .iClear(clr[1]),
      .iLoad(ld[1]), .iLoadData(ldData[1]),
      .oDigit0(bD0), .oDigit1(bD1), .oDigit2(bD2), .oDigit3(bD3),
      .oCarry(bC), .oBorrow(bB), .oZero(bZ));

   always #5 clk = ~clk;

   typedef struct {
      int          k;
      logic [15:0] dig;
      logic        c;
      logic        b;
      logic        z;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   mVal[2];
   int   mPresc[2];
   int   carryCnt[2];
   int   borrowCnt[2];

   function automatic int divOf(input int k);
      return (k == 0) ? 4 : 1;
   endfunction

   function automatic logic [15:0] toBcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic int decodeLoad(input logic [15:0] d);
      int v;
      int n;
      v = 0;
      for (int i = 3; i >= 0; i--) begin
         n = int'(d[i*4 +: 4]);
         if (n > 9) n = 0;
         v = v * 10 + n;
      end
      return v;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance the decimal model for instance k by one clock, using the inputs
   // now driven. Push the values the outputs must show after the edge.
   task automatic modelStep(input int k);
      exp_t e;
      bit   tick;
      tick = (mPresc[k] == divOf(k) - 1);
      e.k = k;
      e.c = 1'b0;
      e.b = 1'b0;
      if (clr[k]) begin
         mVal[k]   = 0;
         mPresc[k] = 0;
      end else if (ld[k]) begin
         mVal[k]   = decodeLoad(ldData[k]);
         mPresc[k] = 0;
      end else begin
         mPresc[k] = tick ? 0 : mPresc[k] + 1;
         if (tick && en[k]) begin
            if (up[k]) begin
               if (mVal[k] == 9999) begin mVal[k] = 0; e.c = 1'b1; end
               else mVal[k] = mVal[k] + 1;
            end else begin
               if (mVal[k] == 0) begin mVal[k] = 9999; e.b = 1'b1; end
               else mVal[k] = mVal[k] - 1;
            end
         end
      end
      e.dig = toBcd(mVal[k]);
      e.z   = (mVal[k] == 0);
      sb.push_back(e);
   endtask

   task automatic cyc(input int n);
      exp_t        e;
      logic [15:0] bad;
      repeat (n) begin
         for (int k = 0; k < 2; k++) modelStep(k);
         @(posedge clk);
         #1;
         for (int j = 0; j < 2; j++) begin
            e   = sb.pop_front();
            bad = '0;
            for (int q = 0; q < 4; q++)
               if (obsDig[e.k][q*4 +: 4] > 4'd9) bad = 16'd1;
            chk($sformatf("digits%0d", e.k), obsDig[e.k], e.dig);
            chk($sformatf("carry%0d", e.k), 16'(obsC[e.k]), 16'(e.c));
            chk($sformatf("borrow%0d", e.k), 16'(obsB[e.k]), 16'(e.b));
            chk($sformatf("zero%0d", e.k), 16'(obsZ[e.k]), 16'(e.z));
            chk($sformatf("nibble%0d", e.k), bad, 16'd0);
            if (obsC[e.k]) carryCnt[e.k]++;
            if (obsB[e.k]) borrowCnt[e.k]++;
         end
      end
   endtask

   // Assert reset away from the clock edge and check that it acts at once.
   // Then release it one edge later.
   task automatic doReset();
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rstDigits%0d", k), obsDig[k], 16'h0000);
         chk($sformatf("rstCarry%0d", k), 16'(obsC[k]), 16'd0);
         chk($sformatf("rstBorrow%0d", k), 16'(obsB[k]), 16'd0);
         chk($sformatf("rstZero%0d", k), 16'(obsZ[k]), 16'd1);
         mVal[k]   = 0;
         mPresc[k] = 0;
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      en = '0; up = '0; clr = '0; ld = '0;
      ldData[0] = '0; ldData[1] = '0;
      carryCnt  = '{0, 0};
      borrowCnt = '{0, 0};
      #2;
      doReset();

      // Count up from reset: 40 cycles give 10 ticks.
      en[0] = 1'b1; up[0] = 1'b1;
      cyc(40);
      chk("upTo10", obsDig[0], 16'h0010);

      // Up-count wrap from 9999 to 0000.
      ld[0] = 1'b1; ldData[0] = 16'h9998;
      cyc(1);
      ld[0] = 1'b0; carryCnt[0] = 0;
      cyc(12);
      chk("carryOnce", 16'(carryCnt[0]), 16'd1);
      chk("after9999", obsDig[0], 16'h0001);

      // Down-count wrap from 0000 to 9999.
      ld[0] = 1'b1; ldData[0] = 16'h0001; up[0] = 1'b0;
      cyc(1);
      ld[0] = 1'b0; borrowCnt[0] = 0;
      cyc(12);
      chk("borrowOnce", 16'(borrowCnt[0]), 16'd1);
      chk("after0000", obsDig[0], 16'h9998);

      // An illegal load nibble becomes 0. Clear beats a simultaneous load.
      en[0] = 1'b0;
      ld[0] = 1'b1; ldData[0] = 16'hFA3C;
      cyc(1);
      chk("loadSanitize", obsDig[0], 16'h0030);
      clr[0] = 1'b1; ldData[0] = 16'h1234;
      cyc(1);
      chk("clearBeatsLoad", obsDig[0], 16'h0000);
      clr[0] = 1'b0; ld[0] = 1'b0;

      // Pause and resume. The tick phase is kept across the pause.
      ld[0] = 1'b1; ldData[0] = 16'h0050; en[0] = 1'b1; up[0] = 1'b1;
      cyc(1);
      ld[0] = 1'b0;
      cyc(28);
      chk("at0057", obsDig[0], 16'h0057);
      en[0] = 1'b0;
      cyc(10);
      chk("paused0057", obsDig[0], 16'h0057);
      en[0] = 1'b1;
      cyc(6);
      chk("resumePhase", obsDig[0], 16'h0059);

      // Load held high blocks counting.
      ld[0] = 1'b1; ldData[0] = 16'h0100;
      cyc(9);
      chk("loadHeld", obsDig[0], 16'h0100);
      ld[0] = 1'b0;

      // Reset asserted while a borrow is pending. No pulse may appear later.
      clr[0] = 1'b1; up[0] = 1'b0;
      cyc(1);
      clr[0] = 1'b0;
      cyc(3);
      #3;
      doReset();
      borrowCnt[0] = 0; carryCnt[0] = 0;
      up[0] = 1'b1;
      cyc(5);
      chk("noBorrowAfterRst", 16'(borrowCnt[0]), 16'd0);
      chk("noCarryAfterRst", 16'(carryCnt[0]), 16'd0);
      chk("afterRstCount", obsDig[0], 16'h0001);

      // TICK_DIV=1: counts every cycle across the 9999 wrap.
      en[0] = 1'b0;
      ld[1] = 1'b1; ldData[1] = 16'h9990; en[1] = 1'b1; up[1] = 1'b1;
      cyc(1);
      ld[1] = 1'b0; carryCnt[1] = 0;
      cyc(12);
      chk("div1Carry", 16'(carryCnt[1]), 16'd1);
      chk("div1Final", obsDig[1], 16'h0002);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
